// File: rtl/divisor_inverso_mult.sv
// Iterative signed shift-and-add unit regenerating Prod = Coc*Den + Res (inverse of the divider).
// Define DIV_INV_OVF_EN to build the Ovf detector; otherwise Ovf is tied to 0.
module divisor_inverso_mult #(
    parameter int unsigned tamanyo = 32
) (
    input  logic                   CLK,
    input  logic                   RSTa,
    input  logic                   Start,
    input  logic [tamanyo-1:0]     Coc,
    input  logic [tamanyo-1:0]     Den,
    input  logic [tamanyo-1:0]     Res,
    output logic [2*tamanyo-1:0]   Prod,
    output logic [tamanyo-1:0]     Num,
    output logic                   Busy,
    output logic                   Done,
    output logic                   Ovf
);

    localparam int unsigned W2   = 2 * tamanyo;
    localparam int unsigned CntW = $clog2(tamanyo + 1);

    localparam logic [tamanyo-1:0] OneW    = 1;
    localparam logic [W2-1:0]      One2    = 1;
    localparam logic [CntW-1:0]    CntOne  = 1;
    localparam logic [CntW-1:0]    CntLoad = CntW'(tamanyo);

    typedef enum logic [1:0] {StIdle, StMul, StFix, StDone} state_t;

    state_t              state_q, state_d;
    logic                sign_q, sign_d;
    logic [W2-1:0]       mcand_q, mcand_d;
    logic [tamanyo-1:0]  mlt_q, mlt_d;
    logic [W2-1:0]       res_q, res_d;
    logic [W2-1:0]       acc_q, acc_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [W2-1:0]       prod_q, prod_d;
    logic [tamanyo-1:0]  coc_abs, den_abs;
    logic [W2-1:0]       fix_val;

    // The most negative operand wraps to 2^(tamanyo-1), which is correct as unsigned.
    assign coc_abs = Coc[tamanyo-1] ? (~Coc + OneW) : Coc;
    assign den_abs = Den[tamanyo-1] ? (~Den + OneW) : Den;
    assign fix_val = (sign_q ? (~acc_q + One2) : acc_q) + res_q;

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        mcand_d = mcand_q;
        mlt_d   = mlt_q;
        res_d   = res_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (Start) begin
                    sign_d  = Coc[tamanyo-1] ^ Den[tamanyo-1];
                    mcand_d = {{tamanyo{1'b0}}, coc_abs};
                    mlt_d   = den_abs;
                    res_d   = {{tamanyo{Res[tamanyo-1]}}, Res};
                    acc_d   = '0;
                    cnt_d   = CntLoad;
                    state_d = StMul;
                end else begin
                    state_d = StIdle;
                end
            end
            StMul: begin
                if (mlt_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d = mcand_q << 1;
                mlt_d   = mlt_q >> 1;
                cnt_d   = cnt_q - CntOne;
                if (cnt_q <= CntOne) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                prod_d  = fix_val;
                state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            state_q <= StIdle;
            sign_q  <= 1'b0;
            mcand_q <= '0;
            mlt_q   <= '0;
            res_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            mcand_q <= mcand_d;
            mlt_q   <= mlt_d;
            res_q   <= res_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

`ifdef DIV_INV_OVF_EN
    logic ovf_q, ovf_d;
    logic [tamanyo:0] top_bits;

    // Representable in tamanyo bits only if the upper half plus the msb of Num are all equal.
    assign top_bits = fix_val[W2-1:tamanyo-1];

    always_comb begin
        ovf_d = ovf_q;
        if (state_q == StFix) begin
            ovf_d = ~((&top_bits) | ~(|top_bits));
        end
    end

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign Ovf = ovf_q;
`else
    assign Ovf = 1'b0;
`endif

    assign Prod = prod_q;
    assign Num  = prod_q[tamanyo-1:0];
    assign Busy = (state_q == StMul) || (state_q == StFix);
    assign Done = (state_q == StDone);

endmodule

// File: tb/tb_divisor_inverso_mult.sv
// Directed bench for divisor_inverso_mult at tamanyo=8; honours DIV_INV_OVF_EN for Ovf expectations.
module tb_divisor_inverso_mult;

    localparam int unsigned W = 8;
`ifdef DIV_INV_OVF_EN
    localparam logic OvfOn = 1'b1;
`else
    localparam logic OvfOn = 1'b0;
`endif

    logic           CLK = 1'b0;
    logic           RSTa = 1'b1;
    logic           Start = 1'b0;
    logic [W-1:0]   Coc = '0;
    logic [W-1:0]   Den = '0;
    logic [W-1:0]   Res = '0;
    logic [2*W-1:0] Prod;
    logic [W-1:0]   Num;
    logic           Busy;
    logic           Done;
    logic           Ovf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    divisor_inverso_mult #(.tamanyo(W)) dut (
        .CLK   (CLK),
        .RSTa  (RSTa),
        .Start (Start),
        .Coc   (Coc),
        .Den   (Den),
        .Res   (Res),
        .Prod  (Prod),
        .Num   (Num),
        .Busy  (Busy),
        .Done  (Done),
        .Ovf   (Ovf)
    );

    // Pulses Start for one edge, then counts negedges until Done (bounded at 20).
    task automatic run_op(input logic [W-1:0] c, input logic [W-1:0] d, input logic [W-1:0] r,
                          output int lat);
        @(negedge CLK);
        Coc = c; Den = d; Res = r; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        lat = 1;
        while (Done !== 1'b1 && lat < 20) begin
            @(negedge CLK);
            lat++;
        end
    endtask

    task automatic test_reset();
        #1 RSTa = 1'b0;
        #2;
        n_checks++;
        if ({Prod, Num, Busy, Done, Ovf} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got Prod=%h Num=%h Busy=%b Done=%b Ovf=%b, want all 0",
                     Prod, Num, Busy, Done, Ovf);
        end
        @(negedge CLK);
        RSTa = 1'b1;
    endtask

    task automatic test_basic();
        logic [W-1:0]   vc  [4] = '{8'h07, 8'hFE, 8'h80, 8'hFB};
        logic [W-1:0]   vd  [4] = '{8'h03, 8'h03, 8'h80, 8'h00};
        logic [W-1:0]   vr  [4] = '{8'h02, 8'hFF, 8'h00, 8'hFD};
        logic [2*W-1:0] vp  [4] = '{16'h0017, 16'hFFF9, 16'h4000, 16'hFFFD};
        logic           vo  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(vc[i], vd[i], vr[i], lat);
            n_checks++;
            if (lat !== 10) begin
                n_fail++;
                $display("FAIL basic%0d_latency: got %0d negedges, want 10", i, lat);
            end
            n_checks++;
            if (Prod !== vp[i]) begin
                n_fail++;
                $display("FAIL basic%0d_prod: got %h want %h", i, Prod, vp[i]);
            end
            n_checks++;
            if (Num !== vp[i][W-1:0]) begin
                n_fail++;
                $display("FAIL basic%0d_num: got %h want %h", i, Num, vp[i][W-1:0]);
            end
            n_checks++;
            if (Ovf !== (vo[i] & OvfOn)) begin
                n_fail++;
                $display("FAIL basic%0d_ovf: got %b want %b", i, Ovf, vo[i] & OvfOn);
            end
            n_checks++;
            if (Busy !== 1'b0) begin
                n_fail++;
                $display("FAIL basic%0d_busy_in_done: got %b want 0", i, Busy);
            end
            @(negedge CLK);
            n_checks++;
            if (Done !== 1'b0 || Prod !== vp[i]) begin
                n_fail++;
                $display("FAIL basic%0d_done_one_cycle: got Done=%b Prod=%h want 0/%h",
                         i, Done, Prod, vp[i]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int n_done = 0;
        logic [2*W-1:0] got = '0;
        @(negedge CLK);
        Coc = 8'h04; Den = 8'h05; Res = 8'h00; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            if (Done === 1'b1) begin
                n_done++;
                got = Prod;
            end
            if (i == 3) begin
                n_checks++;
                if (Busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ignore_busy: got %b want 1", Busy);
                end
                Coc = 8'h09; Den = 8'h09; Res = 8'h09; Start = 1'b1;
            end
            if (i == 4) Start = 1'b0;
            @(negedge CLK);
        end
        n_checks++;
        if (n_done !== 1) begin
            n_fail++;
            $display("FAIL ignore_done_count: got %0d want 1", n_done);
        end
        n_checks++;
        if (got !== 16'h0014) begin
            n_fail++;
            $display("FAIL ignore_prod: got %h want 0014", got);
        end
    endtask

    task automatic test_reset_abort();
        int n_done = 0;
        int lat;
        @(negedge CLK);
        Coc = 8'h03; Den = 8'h03; Res = 8'h00; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        repeat (4) @(negedge CLK);
        RSTa = 1'b0;
        #1;
        n_checks++;
        if ({Prod, Num, Busy, Done, Ovf} !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: got Prod=%h Num=%h Busy=%b Done=%b Ovf=%b, want all 0",
                     Prod, Num, Busy, Done, Ovf);
        end
        repeat (3) begin
            @(negedge CLK);
            if (Done !== 1'b0) n_done++;
        end
        RSTa = 1'b1;
        repeat (12) begin
            @(negedge CLK);
            if (Done !== 1'b0) n_done++;
        end
        n_checks++;
        if (n_done !== 0) begin
            n_fail++;
            $display("FAIL abort_stale_done: got %0d Done cycles want 0", n_done);
        end
        run_op(8'h05, 8'hFC, 8'h01, lat);
        n_checks++;
        if (lat !== 10 || Prod !== 16'hFFED || Num !== 8'hED) begin
            n_fail++;
            $display("FAIL abort_restart: got lat=%0d Prod=%h Num=%h want 10/FFED/ED",
                     lat, Prod, Num);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]   vc [4] = '{8'h01, 8'hFF, 8'h7F, 8'h80};
        logic [W-1:0]   vd [4] = '{8'h01, 8'hFF, 8'h7F, 8'h7F};
        logic [W-1:0]   vr [4] = '{8'h00, 8'hFF, 8'h7F, 8'h80};
        logic [2*W-1:0] vp [4] = '{16'h0001, 16'h0000, 16'h3F80, 16'hC000};
        logic           vo [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        int lat;
        @(negedge CLK);
        Coc = vc[0]; Den = vd[0]; Res = vr[0]; Start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lat = 0;
            do begin
                @(negedge CLK);
                lat++;
            end while (Done !== 1'b1 && lat < 20);
            n_checks++;
            if (lat !== 10) begin
                n_fail++;
                $display("FAIL b2b%0d_period: got %0d want 10", i, lat);
            end
            n_checks++;
            if (Prod !== vp[i] || Ovf !== (vo[i] & OvfOn)) begin
                n_fail++;
                $display("FAIL b2b%0d_result: got Prod=%h Ovf=%b want %h/%b",
                         i, Prod, Ovf, vp[i], vo[i] & OvfOn);
            end
            if (i < 3) begin
                Coc = vc[i+1]; Den = vd[i+1]; Res = vr[i+1];
            end else begin
                Start = 1'b0;
            end
        end
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
